// File: rtl/bus_power_init_sequencer.sv
// Powers up the MOPS CAN buses one at a time after an init request, with an
// optional oscillator-trim handshake per bus and a timeout on each trim.
module bus_power_init_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int TRIM_TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_init,
    input  logic [4:0]  n_buses,
    input  logic        osc_auto_trim,
    input  logic        end_trim_bus,
    output logic        power_bus_en,
    output logic [4:0]  power_bus_cnt,
    output logic        start_trim_ack,
    output logic        end_power_init,
    output logic        busy,
    output logic [31:0] trim_fail_mask
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TRIM_TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TRIM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POWER_ON,
        TRIM_REQ,
        TRIM_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [4:0]    last_q, last_d;
    logic          trim_q, trim_d;
    logic [4:0]    cnt_d;
    logic [31:0]   mask_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        last_d   = last_q;
        trim_d   = trim_q;
        cnt_d    = power_bus_cnt;
        mask_d   = trim_fail_mask;
        case (state_q)
            IDLE: begin
                if (start_init) begin
                    last_d   = n_buses;
                    trim_d   = osc_auto_trim;
                    cnt_d    = '0;
                    mask_d   = '0;
                    settle_d = '0;
                    state_d  = POWER_ON;
                end
            end
            POWER_ON: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = trim_q ? TRIM_REQ : NEXT;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            TRIM_REQ: begin
                tmo_d   = '0;
                state_d = TRIM_WAIT;
            end
            TRIM_WAIT: begin
                // A done pulse on the last timeout cycle still counts as success.
                if (end_trim_bus) begin
                    state_d = NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    mask_d[power_bus_cnt] = 1'b1;
                    state_d = NEXT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            NEXT: begin
                if (power_bus_cnt == last_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = power_bus_cnt + 5'd1;
                    state_d = POWER_ON;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            tmo_q          <= '0;
            last_q         <= '0;
            trim_q         <= 1'b0;
            power_bus_cnt  <= '0;
            trim_fail_mask <= '0;
            power_bus_en   <= 1'b0;
            start_trim_ack <= 1'b0;
            end_power_init <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            settle_q       <= settle_d;
            tmo_q          <= tmo_d;
            last_q         <= last_d;
            trim_q         <= trim_d;
            power_bus_cnt  <= cnt_d;
            trim_fail_mask <= mask_d;
            power_bus_en   <= (state_d == POWER_ON) || (state_d == TRIM_REQ) ||
                              (state_d == TRIM_WAIT);
            start_trim_ack <= (state_d == TRIM_REQ);
            end_power_init <= (state_d == DONE);
            busy           <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_bus_power_init_sequencer.sv
// Self-checking bench: per-cycle output trace compared against a timeline
// built arithmetically from bus count, settle time and trim-ack offsets.
`timescale 1ns/1ps
module tb_bus_power_init_sequencer;

    localparam int S  = 16;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_init;
    logic [4:0]  n_buses;
    logic        osc_auto_trim;
    logic        end_trim_bus;
    logic        power_bus_en;
    logic [4:0]  power_bus_cnt;
    logic        start_trim_ack;
    logic        end_power_init;
    logic        busy;
    logic [31:0] trim_fail_mask;

    bus_power_init_sequencer #(.SETTLE_CYCLES(S), .TRIM_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_init     (start_init),
        .n_buses        (n_buses),
        .osc_auto_trim  (osc_auto_trim),
        .end_trim_bus   (end_trim_bus),
        .power_bus_en   (power_bus_en),
        .power_bus_cnt  (power_bus_cnt),
        .start_trim_ack (start_trim_ack),
        .end_power_init (end_power_init),
        .busy           (busy),
        .trim_fail_mask (trim_fail_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  cnt;
        logic        ack;
        logic        endp;
        logic        busy;
        logic [31:0] mask;
    } obs_t;

    obs_t exp_q[$];
    bit   drv[];
    int   off1[32];
    int   off2[32];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t sample();
        return {power_bus_en, power_bus_cnt, start_trim_ack, end_power_init, busy, trim_fail_mask};
    endfunction

    // Expected trace, cycle k = interval after edge E0+k.
    task automatic build_model(input int n, input bit trim);
        obs_t        r;
        logic [31:0] m;
        int          a, w, l;
        bit          hit;
        int          marks[$];
        m = '0;
        exp_q.delete();
        for (int b = 0; b <= n; b++) begin
            r = '{en: 1'b1, cnt: 5'(b), ack: 1'b0, endp: 1'b0, busy: 1'b1, mask: m};
            repeat (S) exp_q.push_back(r);
            if (trim) begin
                r.ack = 1'b1;
                exp_q.push_back(r);
                a = exp_q.size() - 1;
                r.ack = 1'b0;
                w = TO;
                hit = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    l = (j == 0) ? off1[b] : off2[b];
                    if (l >= 0) marks.push_back(a + l);
                    if (l >= 1 && l <= TO && (!hit || l < w)) begin
                        w = l;
                        hit = 1'b1;
                    end
                end
                repeat (w) exp_q.push_back(r);
                if (!hit) m[b] = 1'b1;
            end
            r.en = 1'b0;
            r.mask = m;
            exp_q.push_back(r);
        end
        r = '{en: 1'b0, cnt: 5'(n), ack: 1'b0, endp: 1'b1, busy: 1'b1, mask: m};
        exp_q.push_back(r);
        r.endp = 1'b0;
        r.busy = 1'b0;
        exp_q.push_back(r);
        drv = new[exp_q.size()];
        foreach (drv[i]) drv[i] = 1'b0;
        foreach (marks[i]) if (marks[i] < exp_q.size()) drv[marks[i]] = 1'b1;
    endtask

    task automatic run_seq(input int n, input bit trim, input bit keep_start, input int abort_k);
        obs_t o;
        bit   seen;
        build_model(n, trim);
        start_init    = 1'b1;
        n_buses       = 5'(n);
        osc_auto_trim = trim;
        end_trim_bus  = 1'b0;
        @(posedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            end_trim_bus = drv[k];
            if (!keep_start) start_init = 1'b0;
            n_buses       = 5'($urandom);
            osc_auto_trim = 1'($urandom);
            if (k == abort_k) begin
                #2 rst = 1'b0;
                #1;
                o = sample();
                n_cmp++;
                assert (o === obs_t'(0)) else begin
                    n_bad++;
                    $error("FAIL abort_reset obs=%h exp=%h", o, obs_t'(0));
                end
                start_init = 1'b0;
                end_trim_bus = 1'b0;
                @(negedge clk) rst = 1'b1;
                seen = 1'b0;
                repeat (300) begin
                    @(negedge clk);
                    if (end_power_init !== 1'b0 || busy !== 1'b0) seen = 1'b1;
                end
                n_cmp++;
                assert (seen === 1'b0) else begin
                    n_bad++;
                    $error("FAIL post_abort_quiet obs=%0b exp=0", seen);
                end
                return;
            end
            @(negedge clk);
            o = sample();
            n_cmp++;
            assert (o === exp_q[k]) else begin
                n_bad++;
                $error("FAIL cyc n=%0d k=%0d obs=%h exp=%h", n, k, o, exp_q[k]);
            end
            if (k < exp_q.size() - 1) @(posedge clk);
        end
    endtask

    task automatic set_offs(input int a1, input int a2);
        for (int b = 0; b < 32; b++) begin
            off1[b] = a1;
            off2[b] = a2;
        end
    endtask

    task automatic rand_offs();
        for (int b = 0; b < 32; b++) begin
            off1[b] = int'($urandom_range(0, TO + 4)) - 1;
            off2[b] = int'($urandom_range(0, TO + 4)) - 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        rst = 1'b0;
        start_init = 1'b1;
        n_buses = 5'd7;
        osc_auto_trim = 1'b1;
        end_trim_bus = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        o = sample();
        n_cmp++;
        assert (o === obs_t'(0)) else begin
            n_bad++;
            $error("FAIL reset_hold obs=%h exp=%h", o, obs_t'(0));
        end
        start_init = 1'b0;
        end_trim_bus = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        o = sample();
        n_cmp++;
        assert (o === obs_t'(0)) else begin
            n_bad++;
            $error("FAIL idle_after_reset obs=%h exp=%h", o, obs_t'(0));
        end

        set_offs(-1, -1);
        run_seq(15, 1'b0, 1'b0, -1);

        set_offs(5, -1);
        run_seq(3, 1'b1, 1'b0, -1);

        set_offs(3, -1);
        off1[1] = -1;
        run_seq(2, 1'b1, 1'b0, -1);

        set_offs(int'($urandom_range(1, TO)), -1);
        run_seq(0, 1'b1, 1'b0, -1);
        run_seq(0, 1'b0, 1'b0, -1);

        set_offs(0, 4);
        run_seq(1, 1'b1, 1'b0, -1);

        set_offs(7, -1);
        off1[0] = TO;
        off1[1] = TO + 1;
        run_seq(2, 1'b1, 1'b0, -1);

        run_seq(31, 1'b0, 1'b0, -1);

        set_offs(-1, -1);
        off1[0] = 2;
        run_seq(2, 1'b1, 1'b1, -1);
        rand_offs();
        run_seq(1, 1'b1, 1'b1, -1);
        run_seq(0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            rand_offs();
            run_seq(int'($urandom_range(0, 4)), 1'($urandom), 1'b0, -1);
        end

        run_seq(15, 1'b0, 1'b0, 7 * (S + 1) + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_power_init_sequencer.md
# bus_power_init_sequencer

Sequences power-up of the MOPS CAN buses inside `mopshub_top` after initialization is requested.
- Enables each bus in turn, 0 … `n_buses`, and holds it for a settle interval.
- Optionally hands each bus to the oscillator-trim engine and waits for its completion.
- Pulses `end_power_init` when all buses are done.
- Sits between the init controller (`start_init`) and the trim engine (`start_trim_ack`/`end_trim_bus`). `power_bus_en`/`power_bus_cnt` drive the bus power switches and the bench data generator.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16 — clocks each bus is powered before trim/next; ≥1.
- `TRIM_TIMEOUT`, 4096 — max clocks spent in TRIM_WAIT per bus; ≥2.

Ports:
- `clk`  in  1  system clock (40 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `start_init`  in  1  start request; level, sampled only in IDLE.
- `n_buses`  in  5  index of last bus (15 → 16 buses); latched at start.
- `osc_auto_trim`  in  1  1 = run trim step per bus; latched at start.
- `end_trim_bus`  in  1  trim-done pulse from trim engine.
- `power_bus_en`  out  1  current bus powered/being processed.
- `power_bus_cnt`  out  5  current bus index.
- `start_trim_ack`  out  1  1-cycle trim request for `power_bus_cnt`.
- `end_power_init`  out  1  1-cycle completion pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `trim_fail_mask`  out  32  bit b set if bus b trim timed out.

## Operation
- States: IDLE, POWER_ON, TRIM_REQ, TRIM_WAIT, NEXT, DONE.
- **IDLE**:
  - On `start_init`=1: latch `n_buses` and `osc_auto_trim`, clear `power_bus_cnt` and `trim_fail_mask`, clear the settle counter, go to POWER_ON.
- **POWER_ON**:
  - `power_bus_en`=1; stays exactly `SETTLE_CYCLES` cycles.
  - Then go to TRIM_REQ if latched trim=1, else NEXT.
- **TRIM_REQ**:
  - 1 cycle; `start_trim_ack`=1 and `power_bus_en`=1.
  - Go to TRIM_WAIT; clear the timeout counter.
- **TRIM_WAIT**:
  - `power_bus_en`=1.
  - Leave on `end_trim_bus`=1 → NEXT.
  - Leave when timeout counter reaches `TRIM_TIMEOUT`-1 → set `trim_fail_mask[power_bus_cnt]`, then NEXT.
  - If both happen in the same cycle, `end_trim_bus` wins: no fail bit.
- **NEXT**:
  - 1 cycle; `power_bus_en`=0 (gap between buses).
  - If `power_bus_cnt` == latched `n_buses`, go to DONE; `power_bus_cnt` holds.
  - Else increment `power_bus_cnt` and go to POWER_ON.
- **DONE**:
  - 1 cycle; `end_power_init`=1; then IDLE.
  - `power_bus_cnt` and `trim_fail_mask` hold until the next start.
- `end_trim_bus` outside TRIM_WAIT (including the TRIM_REQ cycle) is ignored.
- `start_init` outside IDLE is ignored; a level still high when DONE returns to IDLE restarts the sequence.
- Changes to `n_buses` or `osc_auto_trim` mid-sequence have no effect.
- `n_buses`=0: a single bus is processed.
- `n_buses`=31: the counter reaches 31 without wrapping.

## Timing
- All outputs are registered; state-decoded outputs are valid in the cycle after the state-changing edge.
- Reset (`rst`=0, asynchronous): state IDLE, all outputs 0 (`trim_fail_mask`=0, `power_bus_cnt`=0), counters 0.
- Reset mid-sequence aborts immediately; no `end_power_init` is produced.
- Let E0 be the edge sampling `start_init`:
  - Bus b enters POWER_ON after edge E0 + b·P, where P = `SETTLE_CYCLES`+1 without trim.
  - With trim, P = `SETTLE_CYCLES` + 2 + W, where W ≥ 1 is TRIM_WAIT occupancy.
- Without trim, `end_power_init` is high in the cycle after edge E0 + (`n_buses`+1)·(`SETTLE_CYCLES`+1).
  - Defaults, `n_buses`=15: edge E0+272.
- `start_trim_ack` is high in the cycle after edge E0 + b·P + `SETTLE_CYCLES`.
- Timeout: TRIM_WAIT lasts exactly `TRIM_TIMEOUT` cycles when no `end_trim_bus` arrives.
- `busy` falls in the same cycle that `end_power_init` falls.

## Test plan
- **Reset**: hold `rst`=0 → all outputs 0. Pulse `rst`=0 at bus 7 mid-POWER_ON → `power_bus_en`=0 and `busy`=0 immediately; no `end_power_init` afterwards.
- **No trim**: `n_buses`=15, `osc_auto_trim`=0, 1-cycle `start_init` → `power_bus_cnt` steps 0..15, each with `power_bus_en` high 16 cycles and a 1-cycle gap; `end_power_init` pulses once at E0+272; `start_trim_ack` is never asserted.
- **Trim, responsive**: `n_buses`=3, trim=1, model acks 5 cycles after each `start_trim_ack` → 4 trim requests, each for the matching bus index; `trim_fail_mask`=0; one `end_power_init`.
- **Trim timeout**: `TRIM_TIMEOUT`=8, `n_buses`=2, no ack on bus 1 → bus 1 TRIM_WAIT lasts 8 cycles; `trim_fail_mask`=32'h2; sequence completes.
- **Boundaries**:
  - `n_buses`=0 → one bus only.
  - `end_trim_bus` coincident with `start_trim_ack` → ignored; the later ack is accepted.
  - Ack on the final timeout cycle → no fail bit.
  - Change `n_buses` mid-run → no effect.
- **Restart**: hold `start_init`=1 continuously → back-to-back sequences; `trim_fail_mask` clears at each new start.
